sim_run_controller: RTL
=======================

Name: sim_run_controller

Overview:
- Synthesizable run controller for RV32I core simulation; generalises the fixed "reset, run 500 cycles, stop" flow.
- Sequences the core's reset for a parametrised number of cycles and counts cycles and retired instructions.
- Ends the run on a tohost store, a PC self-loop, or a cycle timeout, and reports status and exit code.
- Sits beside the core in the bench top; the bench polls `done` before calling `$stop`.

Parameters:
- XLEN, 32, width of pc, address and data buses
- RESET_CYCLES, 2, cycles core_reset is held after controller reset release (minimum 1)
- MAX_CYCLES, 500, RUN-state cycle limit before timeout (minimum 1)
- CNT_W, 32, width of cycle and instret counters
- TOHOST_ADDR, 32'h0000_1000, store address that signals program exit
- LOOP_DETECT, 1, 1 enables PC self-loop halt detection
- LOOP_REPEAT, 4, consecutive retirements at an unchanged PC that count as a halt

Ports:
- clk, in, 1, system clock, all logic on rising edge
- reset, in, 1, synchronous active-low reset (0 = reset)
- pc, in, XLEN, core PC of the instruction retiring this cycle
- retire, in, 1, one instruction retires this cycle
- dmem_wren, in, 1, core data-memory write enable
- dmem_addr, in, XLEN, core data-memory address
- dmem_wdata, in, XLEN, core data-memory write data
- core_reset, out, 1, active-high reset to the core
- cycle_count, out, CNT_W, cycles spent in RUN
- instret_count, out, CNT_W, retired instructions in RUN
- done, out, 1, run finished (sticky)
- pass, out, 1, finished with tohost value 1
- timeout, out, 1, finished because MAX_CYCLES was reached
- exit_code, out, XLEN, tohost value, or PC on loop/timeout

Behaviour:
- Reset values (reset=0 at an edge):
  - state=HOLD; core_reset=1.
  - hold counter, cycle_count, instret_count, loop counter and exit_code all 0.
  - done, pass and timeout all 0.
- Reset has priority over every other event and aborts any state, including DONE.
- HOLD state:
  - core_reset=1.
  - The hold counter increments each cycle.
  - When it reaches RESET_CYCLES-1, the next state is RUN.
  - So core_reset is 1 for exactly RESET_CYCLES cycles after reset rises.
- RUN state:
  - core_reset=0.
  - cycle_count increments every cycle.
  - instret_count increments when retire=1.
- Exit conditions are evaluated on each RUN cycle, in this priority order:
  1. tohost: dmem_wren=1 and dmem_addr==TOHOST_ADDR. Sets done=1, exit_code=dmem_wdata, pass=(dmem_wdata==1).
  2. loop: LOOP_DETECT=1 and the loop counter reaches LOOP_REPEAT. Sets done=1, exit_code=pc, pass=0.
  3. timeout: cycle_count==MAX_CYCLES-1 on this cycle. Sets done=1, timeout=1, exit_code=pc, pass=0.
- On any exit the next state is DONE.
- The counters include the terminating cycle: its cycle, plus its retirement if retire=1.
- Loop counter:
  - On a retire with pc equal to the registered last_pc, the counter increments, saturating at LOOP_REPEAT.
  - On a retire with a different pc, the counter clears to 0 and last_pc loads pc.
  - Cycles with no retire leave the counter unchanged.
  - The first retirement after HOLD always loads last_pc; last_pc is invalid until then.
- DONE state:
  - core_reset=1, freezing the core.
  - All outputs hold their values.
  - Only reset leaves DONE.
- Counters wrap modulo 2^CNT_W. A timeout is still detected when MAX_CYCLES < 2^CNT_W.
- If tohost and timeout occur on the same cycle, tohost wins: timeout=0 and pass follows wdata.
- Writes to TOHOST_ADDR during HOLD or DONE are ignored.
- No combinational path from inputs to outputs.
- Implementation: 3-state FSM plus registered outputs.

Test Plan:
- Reset and hold: reset=0 for 2 cycles, then 1, with RESET_CYCLES=3 -> core_reset=1 for exactly 3 edges after release, then 0. cycle_count=0 until the first RUN edge.
- Tohost pass: 10 cycles in RUN with retire=1, then a store of 1 to 0x1000 -> done=1, pass=1, timeout=0, exit_code=1, cycle_count=11, instret_count=11, core_reset=1 on the following cycle.
- Tohost fail plus simultaneous timeout: MAX_CYCLES=20, store of 5 to 0x1000 on RUN cycle 20 -> done=1, pass=0, timeout=0, exit_code=5.
- Self-loop: retire every cycle with pc=0x40 after pc=0x3C, LOOP_REPEAT=4 -> done=1 once the counter reaches 4 (the 5th consecutive 0x40 retirement), exit_code=0x40, pass=0. With LOOP_DETECT=0 the same stimulus ends in timeout at MAX_CYCLES.
- Timeout: MAX_CYCLES=500, no stores, pc varying -> done=1 and timeout=1 exactly on the 500th RUN cycle, cycle_count=500, exit_code=pc on that cycle.
- Reset mid-run and in DONE: drive reset=0 at RUN cycle 7, and again while in DONE -> all outputs return to reset values next edge, and HOLD restarts.

Source files
------------

// File: rtl/sim_run_controller.sv
// Run controller for RV32I core simulation: sequences core reset, counts
// cycles and retirements, and ends the run on tohost, PC self-loop or timeout.
module sim_run_controller #(
    parameter int              XLEN         = 32,
    parameter int              RESET_CYCLES = 2,
    parameter int              MAX_CYCLES   = 500,
    parameter int              CNT_W        = 32,
    parameter logic [XLEN-1:0] TOHOST_ADDR  = XLEN'(32'h0000_1000),
    parameter int              LOOP_DETECT  = 1,
    parameter int              LOOP_REPEAT  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  pc,
    input  logic             retire,
    input  logic             dmem_wren,
    input  logic [XLEN-1:0]  dmem_addr,
    input  logic [XLEN-1:0]  dmem_wdata,
    output logic             core_reset,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [XLEN-1:0]  exit_code
);

    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int LW = $clog2(LOOP_REPEAT + 1);

    localparam logic [HW-1:0]    HOLD_LAST = HW'(RESET_CYCLES - 1);
    localparam logic [LW-1:0]    LOOP_LAST = LW'(LOOP_REPEAT - 1);
    localparam logic [LW-1:0]    LOOP_SAT  = LW'(LOOP_REPEAT);
    localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        HOLD,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [HW-1:0]   hold_cnt;
    logic [LW-1:0]   loop_cnt;
    logic [XLEN-1:0] last_pc;
    logic            last_valid;
    logic            same_pc;
    logic            hit_tohost;
    logic            hit_loop;
    logic            hit_timeout;

    assign same_pc    = last_valid && (pc == last_pc);
    assign core_reset = (state != RUN);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= HOLD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        hit_tohost  = 1'b0;
        hit_loop    = 1'b0;
        hit_timeout = 1'b0;
        unique case (state)
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                hit_tohost  = dmem_wren && (dmem_addr == TOHOST_ADDR);
                // Counter reaches LOOP_REPEAT on this retirement
                hit_loop    = (LOOP_DETECT != 0) && retire && same_pc
                              && (loop_cnt == LOOP_LAST);
                hit_timeout = (cycle_count == CYC_LAST);
                if (hit_tohost || hit_loop || hit_timeout) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = state;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_cnt      <= '0;
            cycle_count   <= '0;
            instret_count <= '0;
            loop_cnt      <= '0;
            last_pc       <= '0;
            last_valid    <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            exit_code     <= '0;
        end else if (state == HOLD) begin
            hold_cnt   <= hold_cnt + HW'(1);
            loop_cnt   <= '0;
            last_valid <= 1'b0;
        end else if (state == RUN) begin
            cycle_count <= cycle_count + CNT_W'(1);
            if (retire) begin
                instret_count <= instret_count + CNT_W'(1);
                if (same_pc) begin
                    if (loop_cnt < LOOP_SAT) begin
                        loop_cnt <= loop_cnt + LW'(1);
                    end
                end else begin
                    loop_cnt   <= '0;
                    last_pc    <= pc;
                    last_valid <= 1'b1;
                end
            end
            if (hit_tohost) begin
                done      <= 1'b1;
                exit_code <= dmem_wdata;
                pass      <= (dmem_wdata == XLEN'(1));
            end else if (hit_loop) begin
                done      <= 1'b1;
                exit_code <= pc;
            end else if (hit_timeout) begin
                done      <= 1'b1;
                timeout   <= 1'b1;
                exit_code <= pc;
            end
        end
    end

endmodule
